// File: rtl/sump_cmd_decoder.sv
// SUMP host-protocol byte decoder: short opcodes pulse a strobe, long opcodes collect a 4-byte payload.
// Optional idle abort between payload bytes is enabled by defining SUMP_CMD_TIMEOUT_EN.
module sump_cmd_decoder #(
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic        clk_i,
  input  logic        rst_in,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_stb_i,
  output logic [31:0] cmd_o,
  output logic [1:0]  stg_o,
  output logic        set_mask_o,
  output logic        set_val_o,
  output logic        set_cfg_o,
  output logic        div_o,
  output logic        cnt_o,
  output logic        flgs_o,
  output logic        sftrst_o,
  output logic        arm_o,
  output logic        id_o,
  output logic        meta_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {IDLE, P0, P1, P2, P3} state_e;

  typedef enum int unsigned {
    S_MASK, S_VAL, S_CFG, S_DIV, S_CNT, S_FLGS, S_SFTRST, S_ARM, S_ID, S_META, S_NUM
  } strobe_e;

  if (TIMEOUT < 2) begin : g_timeout_range
    $error("sump_cmd_decoder: TIMEOUT must be >= 2");
  end

  state_e          state_q, state_d;
  logic [7:0]      opcode_q, opcode_d;
  logic [23:0]     shadow_q, shadow_d;
  logic [31:0]     cmd_q, cmd_d;
  logic [1:0]      stg_q, stg_d;
  logic [S_NUM-1:0] strobe_q, strobe_d;
  logic            busy_q, busy_d;

`ifdef SUMP_CMD_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

  // State register
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= IDLE;
      opcode_q  <= '0;
      shadow_q  <= '0;
      cmd_q     <= '0;
      stg_q     <= '0;
      strobe_q  <= '0;
      busy_q    <= 1'b0;
`ifdef SUMP_CMD_TIMEOUT_EN
      tmo_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      shadow_q  <= shadow_d;
      cmd_q     <= cmd_d;
      stg_q     <= stg_d;
      strobe_q  <= strobe_d;
      busy_q    <= busy_d;
`ifdef SUMP_CMD_TIMEOUT_EN
      tmo_cnt_q <= tmo_cnt_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    shadow_d = shadow_q;
`ifdef SUMP_CMD_TIMEOUT_EN
    tmo_cnt_d = '0;
`endif
    if (rx_stb_i) begin
      unique case (state_q)
        IDLE: begin
          if (rx_data_i[7]) begin
            opcode_d = rx_data_i;
            state_d  = P0;
          end
        end
        P0: begin
          shadow_d[7:0] = rx_data_i;
          state_d       = P1;
        end
        P1: begin
          shadow_d[15:8] = rx_data_i;
          state_d        = P2;
        end
        P2: begin
          shadow_d[23:16] = rx_data_i;
          state_d         = P3;
        end
        P3:      state_d = IDLE;
        default: state_d = IDLE;
      endcase
`ifdef SUMP_CMD_TIMEOUT_EN
    end else if (state_q != IDLE) begin
      // An arriving byte always takes precedence, so the abort only fires on idle cycles.
      if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
        state_d = IDLE;
      end else begin
        tmo_cnt_d = tmo_cnt_q + TW'(1);
      end
`endif
    end
  end

  // Output logic
  always_comb begin
    strobe_d = '0;
    cmd_d    = cmd_q;
    stg_d    = stg_q;
    busy_d   = (state_d != IDLE);
    if (rx_stb_i && state_q == IDLE) begin
      unique case (rx_data_i)
        8'h00:   strobe_d[S_SFTRST] = 1'b1;
        8'h01:   strobe_d[S_ARM]    = 1'b1;
        8'h02:   strobe_d[S_ID]     = 1'b1;
        8'h04:   strobe_d[S_META]   = 1'b1;
        default: strobe_d           = '0;
      endcase
    end else if (rx_stb_i && state_q == P3) begin
      unique case (opcode_q)
        8'h80:   strobe_d[S_DIV]  = 1'b1;
        8'h81:   strobe_d[S_CNT]  = 1'b1;
        8'h82:   strobe_d[S_FLGS] = 1'b1;
        8'hC0, 8'hC4, 8'hC8, 8'hCC: strobe_d[S_MASK] = 1'b1;
        8'hC1, 8'hC5, 8'hC9, 8'hCD: strobe_d[S_VAL]  = 1'b1;
        8'hC2, 8'hC6, 8'hCA, 8'hCE: strobe_d[S_CFG]  = 1'b1;
        default: strobe_d = '0;
      endcase
      if (strobe_d != '0) begin
        cmd_d = {rx_data_i, shadow_q};
        stg_d = opcode_q[3:2];
      end
    end
  end

  assign cmd_o      = cmd_q;
  assign stg_o      = stg_q;
  assign busy_o     = busy_q;
  assign set_mask_o = strobe_q[S_MASK];
  assign set_val_o  = strobe_q[S_VAL];
  assign set_cfg_o  = strobe_q[S_CFG];
  assign div_o      = strobe_q[S_DIV];
  assign cnt_o      = strobe_q[S_CNT];
  assign flgs_o     = strobe_q[S_FLGS];
  assign sftrst_o   = strobe_q[S_SFTRST];
  assign arm_o      = strobe_q[S_ARM];
  assign id_o       = strobe_q[S_ID];
  assign meta_o     = strobe_q[S_META];

endmodule

// File: tb/tb_sump_cmd_decoder.sv
// Self-checking bench for sump_cmd_decoder: directed protocol sequences plus random byte streams
// compared each cycle against a queue-based model of the SUMP command framing.
module tb_sump_cmd_decoder;

  localparam int unsigned TMO = 8;

  logic        clk_i = 1'b0;
  logic        rst_in;
  logic [7:0]  rx_data_i;
  logic        rx_stb_i;
  logic [31:0] cmd_o;
  logic [1:0]  stg_o;
  logic        set_mask_o, set_val_o, set_cfg_o, div_o, cnt_o, flgs_o;
  logic        sftrst_o, arm_o, id_o, meta_o, busy_o;
  logic [9:0]  strobes;

  sump_cmd_decoder #(.TIMEOUT(TMO)) dut (
    .clk_i      (clk_i),
    .rst_in     (rst_in),
    .rx_data_i  (rx_data_i),
    .rx_stb_i   (rx_stb_i),
    .cmd_o      (cmd_o),
    .stg_o      (stg_o),
    .set_mask_o (set_mask_o),
    .set_val_o  (set_val_o),
    .set_cfg_o  (set_cfg_o),
    .div_o      (div_o),
    .cnt_o      (cnt_o),
    .flgs_o     (flgs_o),
    .sftrst_o   (sftrst_o),
    .arm_o      (arm_o),
    .id_o       (id_o),
    .meta_o     (meta_o),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // bit order: mask, val, cfg, div, cnt, flgs, sftrst, arm, id, meta
  assign strobes = {meta_o, id_o, arm_o, sftrst_o, flgs_o, cnt_o, div_o,
                    set_cfg_o, set_val_o, set_mask_o};

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference model: bytes of the command in progress, plus last-decoded outputs
  logic [7:0]  cur[$];
  logic [31:0] m_cmd;
  logic [1:0]  m_stg;
  logic [9:0]  m_strb;
  int unsigned m_idle;
  int unsigned busy_cnt;

  task automatic model_reset();
    cur.delete();
    m_cmd  = '0;
    m_stg  = '0;
    m_strb = '0;
    m_idle = 0;
  endtask

  task automatic model_cycle(input logic stb, input logic [7:0] d);
    int unsigned op;
    m_strb = '0;
    if (stb) begin
      m_idle = 0;
      if (cur.size() == 0 && d[7] == 1'b0) begin
        if (d == 8'h00) m_strb[6] = 1'b1;
        if (d == 8'h01) m_strb[7] = 1'b1;
        if (d == 8'h02) m_strb[8] = 1'b1;
        if (d == 8'h04) m_strb[9] = 1'b1;
      end else begin
        cur.push_back(d);
        if (cur.size() == 5) begin
          op = int'(cur[0]);
          if (op >= 'hC0 && op <= 'hCF && (op % 4) != 3) begin
            m_strb[op % 4] = 1'b1;
            m_stg = 2'((op - 'hC0) / 4);
            m_cmd = {cur[4], cur[3], cur[2], cur[1]};
          end else if (op >= 'h80 && op <= 'h82) begin
            m_strb[3 + op - 'h80] = 1'b1;
            m_stg = 2'd0;
            m_cmd = {cur[4], cur[3], cur[2], cur[1]};
          end
          cur.delete();
        end
      end
    end else if (cur.size() != 0) begin
`ifdef SUMP_CMD_TIMEOUT_EN
      m_idle++;
      if (m_idle == TMO) begin
        cur.delete();
        m_idle = 0;
      end
`endif
    end
  endtask

  task automatic check(input string tag);
    logic m_busy;
    m_busy = (cur.size() != 0);
    n_cmp++;
    assert (strobes === m_strb) else begin
      n_err++;
      $error("FAIL %s strobes got %b want %b", tag, strobes, m_strb);
    end
    n_cmp++;
    assert (busy_o === m_busy) else begin
      n_err++;
      $error("FAIL %s busy got %b want %b", tag, busy_o, m_busy);
    end
    n_cmp++;
    assert (cmd_o === m_cmd) else begin
      n_err++;
      $error("FAIL %s cmd got %h want %h", tag, cmd_o, m_cmd);
    end
    n_cmp++;
    assert (stg_o === m_stg) else begin
      n_err++;
      $error("FAIL %s stg got %0d want %0d", tag, stg_o, m_stg);
    end
    n_cmp++;
    assert ($onehot0(strobes)) else begin
      n_err++;
      $error("FAIL %s onehot got %b want at most one bit", tag, strobes);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s got %h want %h", tag, got, want);
    end
  endtask

  task automatic step(input string tag, input logic stb, input logic [7:0] d);
    rx_stb_i  = stb;
    rx_data_i = d;
    model_cycle(stb, d);
    @(posedge clk_i);
    #1;
    if (busy_o === 1'b1) busy_cnt++;
    rx_stb_i = 1'b0;
    check(tag);
  endtask

  task automatic send(input string tag, input logic [7:0] b[$]);
    foreach (b[i]) step(tag, 1'b1, b[i]);
  endtask

  logic [7:0] seq[$];
  logic [7:0] pick[$] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h11, 8'h13, 8'h80, 8'h81,
                         8'h82, 8'hC0, 8'hC5, 8'hCA, 8'hCF, 8'hFF};
  int unsigned n_mask;

  initial begin
    rst_in    = 1'b0;
    rx_stb_i  = 1'b0;
    rx_data_i = '0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check("reset");
    rst_in = 1'b1;
    step("idle", 1'b0, 8'h00);

    busy_cnt = 0;
    seq = '{8'hC0, 8'h78, 8'h56, 8'h34, 8'h12};
    send("set_mask", seq);
    chk32("set_mask_cmd", cmd_o, 32'h1234_5678);
    chk32("set_mask_pulse", {31'd0, set_mask_o}, 32'd1);
    step("set_mask_tail", 1'b0, 8'h00);
    chk32("busy_cycles", busy_cnt, 32'd4);

    seq = '{8'hC6, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h01};
    send("cfg_arm", seq);
    chk32("arm_cmd_hold", cmd_o, 32'hDEAD_BEEF);
    chk32("arm_pulse", {31'd0, arm_o}, 32'd1);

    seq = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send("sftrst_x5", seq);
    seq = '{8'hC5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send("resync", seq);

    seq = '{8'hFF, 8'h01, 8'h02, 8'h03, 8'h04, 8'h11, 8'h02};
    send("unknown", seq);
    chk32("unknown_cmd_hold", cmd_o, 32'h0000_0000);
    chk32("id_pulse", {31'd0, id_o}, 32'd1);

    seq = '{8'hC1, 8'hAA};
    send("timeout_hdr", seq);
    repeat (TMO) step("timeout_idle", 1'b0, 8'h00);
`ifdef SUMP_CMD_TIMEOUT_EN
    chk32("timeout_busy", {31'd0, busy_o}, 32'd0);
`else
    chk32("timeout_busy", {31'd0, busy_o}, 32'd1);
`endif
    step("timeout_meta", 1'b1, 8'h04);

    n_mask = 0;
    seq = '{8'hC8, 8'h11, 8'h22};
    foreach (seq[i]) begin
      step("rst_mid", 1'b1, seq[i]);
      n_mask += set_mask_o;
    end
    rst_in = 1'b0;
    #1;
    model_reset();
    check("rst_async");
    @(posedge clk_i);
    #1;
    check("rst_held");
    rst_in = 1'b1;
    seq = '{8'h82, 8'h01, 8'h00, 8'h00, 8'h00};
    send("flgs", seq);
    chk32("flgs_cmd", cmd_o, 32'h0000_0001);
    chk32("flgs_pulse", {31'd0, flgs_o}, 32'd1);
    n_mask += set_mask_o;
    chk32("no_mask_seen", n_mask, 32'd0);

    for (int unsigned i = 0; i < 600; i++) begin
      logic [7:0] b;
      if ($urandom_range(0, 3) == 0) b = pick[$urandom_range(0, pick.size() - 1)];
      else b = 8'($urandom);
      if (i % 150 == 75) repeat (TMO + 2) step("rand_gap", 1'b0, 8'h00);
      step("rand", $urandom_range(0, 3) != 0, b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
